// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bundles the instruction-memory port, the output handshake and the
// control inputs of the fetch controller.
//   master : the fetch controller (drives imem_addr, out_*, halted, inst_count)
//   slave  : memory / consumer / control side
interface fetch_ctrl_if;
    logic        start;
    logic [4:0]  imem_addr;
    logic [31:0] imem_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [4:0]  out_pc;
    logic        redirect;
    logic [4:0]  redirect_pc;
    logic        halted;
    logic [7:0]  inst_count;

    modport master (
        input  start, imem_inst, out_ready, redirect, redirect_pc,
        output imem_addr, out_valid, out_inst, out_pc, halted, inst_count
    );

    modport slave (
        output start, imem_inst, out_ready, redirect, redirect_pc,
        input  imem_addr, out_valid, out_inst, out_pc, halted, inst_count
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequential instruction fetch with a one-entry valid/ready output stage.
// Fetches from START_ADDR upward, presents each word with its address, stops on a zero
// word or after LAST_ADDR, and restarts from redirect_pc on a redirect.
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst_n - asynchronous active-low reset
//   bus   - fetch_ctrl_if.master: imem_addr/imem_inst memory port, out_valid/out_ready/
//           out_inst/out_pc output stage, start/redirect/redirect_pc control,
//           halted and inst_count status
module fetch_ctrl #(
    parameter logic [4:0] START_ADDR = 5'd1,
    parameter logic [4:0] LAST_ADDR  = 5'd31
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {StIdle, StFetch, StHalt} state_e;

    state_e      state_q, state_d;
    logic [4:0]  pc_q, pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic [4:0]  out_pc_q, out_pc_d;
    logic [7:0]  count_q, count_d;

    logic xfer;
    logic capture;
    logic zero_word;

    assign xfer      = out_valid_q && bus.out_ready;
    // The output slot is free (or being emptied this cycle) and no flush is pending.
    assign capture   = (state_q == StFetch) && !bus.redirect && (!out_valid_q || bus.out_ready);
    assign zero_word = (bus.imem_inst == 32'h0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) state_d = StFetch;
            end
            StFetch: begin
                if (capture && (zero_word || pc_q == LAST_ADDR)) state_d = StHalt;
            end
            StHalt: begin
                if (bus.redirect) state_d = StFetch;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.halted = (state_q == StHalt);
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= 5'd0;
            out_valid_q <= 1'b0;
            out_inst_q  <= 32'h0;
            out_pc_q    <= 5'd0;
            count_q     <= 8'd0;
        end else begin
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
            count_q     <= count_d;
        end
    end

    // Datapath next-state
    always_comb begin
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
        count_d     = count_q;

        // A completed transfer empties the slot unless a capture refills it below.
        if (xfer) begin
            out_valid_d = 1'b0;
            if (count_q != 8'hff) count_d = count_q + 8'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start) pc_d = START_ADDR;
            end
            StFetch, StHalt: begin
                if (bus.redirect) begin
                    out_valid_d = 1'b0;
                    pc_d        = bus.redirect_pc;
                end else if (capture && !zero_word) begin
                    out_valid_d = 1'b1;
                    out_inst_d  = bus.imem_inst;
                    out_pc_d    = pc_q;
                    // LAST_ADDR halts instead of wrapping back to the zero entry.
                    if (pc_q != LAST_ADDR) pc_d = pc_q + 5'd1;
                end
            end
            default: ;
        endcase
    end

    assign bus.imem_addr  = pc_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_inst   = out_inst_q;
    assign bus.out_pc     = out_pc_q;
    assign bus.inst_count = count_q;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter START_ADDR, default 5'd1, first fetch address after start (entry 0 holds a zero word).
REQ-002 SHALL have parameter LAST_ADDR, default 5'd31, highest fetchable address.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  begin fetching from START_ADDR (sampled in IDLE only).
REQ-006 SHALL have port imem_addr  out  5  address to instruction memory, driven directly from pc register.
REQ-007 SHALL have port imem_inst  in  32  memory read data, combinationally valid in the same cycle as imem_addr.
REQ-008 SHALL have port out_valid  out  1  out_inst/out_pc hold a fetched instruction.
REQ-009 SHALL have port out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
REQ-010 SHALL have port out_inst  out  32  fetched instruction word.
REQ-011 SHALL have port out_pc  out  5  address the instruction was fetched from.
REQ-012 SHALL have port redirect  in  1  branch/jump: flush and refetch from redirect_pc.
REQ-013 SHALL have port redirect_pc  in  5  redirect target.
REQ-014 SHALL have port halted  out  1  high in HALT state.
REQ-015 SHALL have port inst_count  out  8  number of accepted transfers, saturating at 255.

Function
REQ-016 SHALL implement states IDLE, FETCH, HALT; busy-state is FETCH.
REQ-017 IDLE: start -> FETCH, pc<=START_ADDR; redirect ignored; start+redirect same cycle -> start wins, pc<=START_ADDR.
REQ-018 FETCH capture condition: !redirect && (!out_valid || out_ready); on capture out_inst<=imem_inst, out_pc<=pc, out_valid<=1.
REQ-019 Capture with imem_inst==32'h0 SHALL not present the word: out_valid<=0 (after any concurrent transfer), state<=HALT, pc unchanged.
REQ-020 Capture of non-zero word at pc==LAST_ADDR SHALL present it and move to HALT; pc SHALL NOT wrap to 0.
REQ-021 Otherwise capture SHALL advance pc<=pc+1; throughput one instruction per cycle while out_ready held high.
REQ-022 out_valid && !out_ready SHALL hold out_inst, out_pc, out_valid and pc stable (no capture, no advance).
REQ-023 out_valid && out_ready with no new capture (HALT, IDLE) SHALL clear out_valid next cycle.
REQ-024 redirect in FETCH or HALT SHALL, next cycle: out_valid<=0 (flush, even if out_ready), pc<=redirect_pc, state<=FETCH; a transfer completing in the redirect cycle still counts.
REQ-025 redirect_pc==0 SHALL be legal; fetches the zero word and halts per REQ-019.
REQ-026 Latency: start at cycle N -> imem_addr==START_ADDR at N+1 -> out_valid with that word at N+2; redirect at N -> new word presented at N+2.
REQ-027 inst_count SHALL increment on each out_valid && out_ready, saturate at 8'd255; cleared only by reset.
REQ-028 halted SHALL equal (state==HALT); HALT persists until redirect or reset; start in HALT ignored.

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE, pc=5'd0, out_valid=0, out_inst=32'h0, out_pc=5'd0, inst_count=0, halted=0, regardless of clk.
REQ-030 Reset asserted mid-FETCH SHALL discard any presented instruction; after release block waits for start.

Verification
REQ-031 Program words 1..4 non-zero, word 5 zero, out_ready=1, start pulse at cycle 0 -> out_pc 1,2,3,4 on cycles 2..5, HALT at cycle 6, halted=1, inst_count=4.
REQ-032 Same program, out_ready low cycles 3-5 -> out_pc==2 and out_inst stable cycles 3-5, imem_addr==3 held, no word lost or duplicated, inst_count=4 at end.
REQ-033 redirect with redirect_pc=5'd10 while out_valid=1, out_ready=0 -> next cycle out_valid=0, imem_addr=10; following cycle out_pc=10.
REQ-034 All 31 words non-zero, out_ready=1 -> out_pc 1..31 presented, HALT after 31, imem_addr stays 31, no fetch of address 0.
REQ-035 rst_n pulsed low between clock edges mid-stream -> outputs zero immediately, state IDLE; start afterward restarts at out_pc=1 with inst_count counting from 0.
REQ-036 In HALT, redirect_pc=5'd2 -> halted=0 next cycle, out_pc=2 presented one cycle later.
